// File: rtl/rf_scoreboard_pkg.sv
// Shared core definitions for the register file scoreboard: default sizes and a
// constant-evaluable ceiling log2.
package rf_scoreboard_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/rf_busy_table.sv
// Busy-bit scoreboard: tracks registers with an outstanding writeback, grants
// destination allocations and keeps a registered count of busy registers.
module rf_busy_table
  import rf_scoreboard_pkg::*;
#(
  parameter int NREG    = NREG_DEF,
  parameter int NRP     = 2,
  parameter int ZERO_R0 = 1,
  localparam int AW     = clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRP*AW-1:0] raddr,
  output logic [NRP-1:0]    rbusy,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic              alloc_valid,
  input  logic [AW-1:0]     alloc_addr,
  output logic              alloc_ready,
  input  logic              flush,
  output logic [AW:0]       busy_cnt
);

  localparam logic ZR = (ZERO_R0 != 0);

  logic [NREG-1:0] busy_q, busy_d;
  logic [AW:0]     cnt_d;
  logic            alloc_zero, do_alloc, do_clear, cnt_inc, cnt_dec;

  // Handshake: an allocation happens on an edge where alloc_valid && alloc_ready;
  // alloc_ready depends only on current state and same-cycle writeback/flush,
  // never on alloc_valid, and a held request without ready changes nothing.
  assign alloc_zero  = ZR && (alloc_addr == '0);
  assign alloc_ready = !flush &&
                       (alloc_zero || !busy_q[alloc_addr] || (we && (waddr == alloc_addr)));
  assign do_alloc    = alloc_valid && alloc_ready && !alloc_zero;
  // A same-register allocation wins over the writeback clear.
  assign do_clear    = we && busy_q[waddr] && !(do_alloc && (alloc_addr == waddr));
  assign cnt_inc     = do_alloc && !busy_q[alloc_addr];
  assign cnt_dec     = do_clear;

  always_comb begin
    busy_d = busy_q;
    cnt_d  = busy_cnt;
    if (flush) begin
      busy_d = '0;
      cnt_d  = '0;
    end else begin
      if (do_clear) busy_d[waddr] = 1'b0;
      if (do_alloc) busy_d[alloc_addr] = 1'b1;
      cnt_d = busy_cnt + {{AW{1'b0}}, cnt_inc} - {{AW{1'b0}}, cnt_dec};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q   <= '0;
      busy_cnt <= '0;
    end else begin
      busy_q   <= busy_d;
      busy_cnt <= cnt_d;
    end
  end

  for (genvar i = 0; i < NRP; i++) begin : g_rbusy
    logic [AW-1:0] a;
    assign a        = raddr[i*AW +: AW];
    assign rbusy[i] = busy_q[a] && !(we && (waddr == a)) && !(ZR && (a == '0));
  end

endmodule

// File: rtl/rf_scoreboard.sv
// Register file with combinational write bypass and an attached busy-bit
// scoreboard for destination allocation.
module rf_scoreboard
  import rf_scoreboard_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int NREG    = NREG_DEF,
  parameter int NRP     = 2,
  parameter int ZERO_R0 = 1,
  localparam int AW     = clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRP*AW-1:0]   raddr,
  output logic [NRP*XLEN-1:0] rdata,
  output logic [NRP-1:0]      rbusy,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic [XLEN-1:0]     wdata,
  input  logic                alloc_valid,
  input  logic [AW-1:0]       alloc_addr,
  output logic                alloc_ready,
  input  logic                flush,
  output logic [AW:0]         busy_cnt
);

  localparam logic ZR = (ZERO_R0 != 0);

  logic [XLEN-1:0] regs_q [NREG];
  logic            wr_en;

  assign wr_en = we && !(ZR && (waddr == '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NREG; k++) regs_q[k] <= '0;
    end else if (wr_en) begin
      regs_q[waddr] <= wdata;
    end
  end

  for (genvar i = 0; i < NRP; i++) begin : g_read
    logic [AW-1:0] a;
    assign a = raddr[i*AW +: AW];
    // Register 0 reads as zero even when the bypass matches it.
    assign rdata[i*XLEN +: XLEN] = (ZR && (a == '0))       ? '0    :
                                   (we && (waddr == a))    ? wdata :
                                                             regs_q[a];
  end

  rf_busy_table #(
    .NREG    (NREG),
    .NRP     (NRP),
    .ZERO_R0 (ZERO_R0)
  ) u_busy (
    .clk         (clk),
    .rst         (rst),
    .raddr       (raddr),
    .rbusy       (rbusy),
    .we          (we),
    .waddr       (waddr),
    .alloc_valid (alloc_valid),
    .alloc_addr  (alloc_addr),
    .alloc_ready (alloc_ready),
    .flush       (flush),
    .busy_cnt    (busy_cnt)
  );

endmodule

// File: tb/tb_rf_scoreboard.sv
// Directed bench for rf_scoreboard: each task drives one scenario and checks
// outputs against hand-computed values.
module tb_rf_scoreboard;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRP  = 2;
  localparam int AW   = 5;

  logic                clk = 1'b0;
  logic                rst;
  logic [NRP*AW-1:0]   raddr;
  logic [NRP*XLEN-1:0] rdata;
  logic [NRP-1:0]      rbusy;
  logic                we;
  logic [AW-1:0]       waddr;
  logic [XLEN-1:0]     wdata;
  logic                alloc_valid;
  logic [AW-1:0]       alloc_addr;
  logic                alloc_ready;
  logic                flush;
  logic [AW:0]         busy_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  rf_scoreboard #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP), .ZERO_R0(1)) dut (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .we(we), .waddr(waddr), .wdata(wdata),
    .alloc_valid(alloc_valid), .alloc_addr(alloc_addr), .alloc_ready(alloc_ready),
    .flush(flush), .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after a rising edge; checks happen 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; waddr = '0; wdata = '0;
    alloc_valid = 1'b0; alloc_addr = '0; flush = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    raddr = {a1, a0};
  endtask

  task automatic test_reset();
    rst = 1'b1; idle(); rd(5'd3, 5'd0);
    tick(); tick();
    rst = 1'b0; #1;
    n_cmp++; if (rdata !== 64'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    n_cmp++; if (rbusy !== 2'b00) begin n_fail++; $display("FAIL reset_rbusy: got %b want 00", rbusy); end
    n_cmp++; if (busy_cnt !== 6'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", busy_cnt); end
    n_cmp++; if (alloc_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", alloc_ready); end
  endtask

  task automatic test_alloc();
    alloc_valid = 1'b1; alloc_addr = 5'd5; #1;
    n_cmp++; if (alloc_ready !== 1'b1) begin n_fail++; $display("FAIL alloc_ready_free: got %b want 1", alloc_ready); end
    tick();
    rd(5'd5, 5'd3); #1;
    n_cmp++; if (rbusy !== 2'b01) begin n_fail++; $display("FAIL alloc_rbusy: got %b want 01", rbusy); end
    n_cmp++; if (busy_cnt !== 6'd1) begin n_fail++; $display("FAIL alloc_cnt: got %0d want 1", busy_cnt); end
    n_cmp++; if (alloc_ready !== 1'b0) begin n_fail++; $display("FAIL alloc_ready_busy: got %b want 0", alloc_ready); end
    tick();
    idle(); #1;
    n_cmp++; if (busy_cnt !== 6'd1) begin n_fail++; $display("FAIL alloc_stall_cnt: got %0d want 1", busy_cnt); end
  endtask

  task automatic test_write_bypass();
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; rd(5'd5, 5'd5); #1;
    n_cmp++; if (rdata !== {32'hDEADBEEF, 32'hDEADBEEF}) begin n_fail++; $display("FAIL bypass_rdata: got %h want deadbeef x2", rdata); end
    n_cmp++; if (rbusy !== 2'b00) begin n_fail++; $display("FAIL bypass_rbusy: got %b want 00", rbusy); end
    tick();
    idle(); #1;
    n_cmp++; if (busy_cnt !== 6'd0) begin n_fail++; $display("FAIL write_clear_cnt: got %0d want 0", busy_cnt); end
    n_cmp++; if (rdata[31:0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL write_stored: got %h want deadbeef", rdata[31:0]); end
    // Write to a non-busy register: data updates, count untouched.
    we = 1'b1; waddr = 5'd6; wdata = 32'h00000066; tick();
    idle(); rd(5'd6, 5'd5); #1;
    n_cmp++; if (rdata !== {32'hDEADBEEF, 32'h00000066}) begin n_fail++; $display("FAIL write_free: got %h want deadbeef00000066", rdata); end
    n_cmp++; if (busy_cnt !== 6'd0) begin n_fail++; $display("FAIL write_free_cnt: got %0d want 0", busy_cnt); end
  endtask

  task automatic test_release_realloc();
    alloc_valid = 1'b1; alloc_addr = 5'd7; tick();
    idle();
    we = 1'b1; waddr = 5'd7; wdata = 32'h77; alloc_valid = 1'b1; alloc_addr = 5'd7; #1;
    n_cmp++; if (alloc_ready !== 1'b1) begin n_fail++; $display("FAIL realloc_ready: got %b want 1", alloc_ready); end
    tick();
    idle(); rd(5'd7, 5'd9); #1;
    n_cmp++; if (rbusy !== 2'b01) begin n_fail++; $display("FAIL realloc_rbusy: got %b want 01", rbusy); end
    n_cmp++; if (busy_cnt !== 6'd1) begin n_fail++; $display("FAIL realloc_cnt: got %0d want 1", busy_cnt); end
    n_cmp++; if (rdata[31:0] !== 32'h77) begin n_fail++; $display("FAIL realloc_data: got %h want 77", rdata[31:0]); end
    // Clear r7 while allocating r9: net zero.
    we = 1'b1; waddr = 5'd7; wdata = 32'h78; alloc_valid = 1'b1; alloc_addr = 5'd9; tick();
    idle(); #1;
    n_cmp++; if (rbusy !== 2'b10) begin n_fail++; $display("FAIL swap_rbusy: got %b want 10", rbusy); end
    n_cmp++; if (busy_cnt !== 6'd1) begin n_fail++; $display("FAIL swap_cnt: got %0d want 1", busy_cnt); end
    we = 1'b1; waddr = 5'd9; wdata = 32'h99; tick();
    idle(); #1;
    n_cmp++; if (busy_cnt !== 6'd0) begin n_fail++; $display("FAIL swap_clear_cnt: got %0d want 0", busy_cnt); end
  endtask

  task automatic test_flush();
    for (int r = 1; r <= 3; r++) begin
      alloc_valid = 1'b1; alloc_addr = AW'(r); tick();
    end
    idle(); #1;
    n_cmp++; if (busy_cnt !== 6'd3) begin n_fail++; $display("FAIL pre_flush_cnt: got %0d want 3", busy_cnt); end
    flush = 1'b1; alloc_valid = 1'b1; alloc_addr = 5'd4;
    we = 1'b1; waddr = 5'd1; wdata = 32'hAA; #1;
    n_cmp++; if (alloc_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %b want 0", alloc_ready); end
    tick();
    idle(); #1;
    n_cmp++; if (busy_cnt !== 6'd0) begin n_fail++; $display("FAIL flush_cnt: got %0d want 0", busy_cnt); end
    for (int r = 1; r <= 4; r += 2) begin
      rd(AW'(r), AW'(r + 1)); #1;
      n_cmp++; if (rbusy !== 2'b00) begin n_fail++; $display("FAIL flush_rbusy_r%0d: got %b want 00", r, rbusy); end
    end
    rd(5'd1, 5'd2); #1;
    n_cmp++; if (rdata[31:0] !== 32'hAA) begin n_fail++; $display("FAIL flush_write: got %h want aa", rdata[31:0]); end
  endtask

  task automatic test_r0();
    we = 1'b1; waddr = 5'd0; wdata = 32'h1234; alloc_valid = 1'b1; alloc_addr = 5'd0;
    rd(5'd0, 5'd0); #1;
    n_cmp++; if (alloc_ready !== 1'b1) begin n_fail++; $display("FAIL r0_ready: got %b want 1", alloc_ready); end
    n_cmp++; if (rdata !== 64'h0) begin n_fail++; $display("FAIL r0_bypass: got %h want 0", rdata); end
    tick();
    idle(); #1;
    n_cmp++; if (rdata !== 64'h0) begin n_fail++; $display("FAIL r0_rdata: got %h want 0", rdata); end
    n_cmp++; if (rbusy !== 2'b00) begin n_fail++; $display("FAIL r0_rbusy: got %b want 00", rbusy); end
    n_cmp++; if (busy_cnt !== 6'd0) begin n_fail++; $display("FAIL r0_cnt: got %0d want 0", busy_cnt); end
  endtask

  task automatic test_reset_override();
    alloc_valid = 1'b1; alloc_addr = 5'd10; tick();
    idle();
    rst = 1'b1; alloc_valid = 1'b1; alloc_addr = 5'd11; we = 1'b1; waddr = 5'd12; wdata = 32'hC0C0;
    tick();
    rst = 1'b0; idle(); rd(5'd5, 5'd12); #1;
    n_cmp++; if (busy_cnt !== 6'd0) begin n_fail++; $display("FAIL rst_ovr_cnt: got %0d want 0", busy_cnt); end
    n_cmp++; if (rdata !== 64'h0) begin n_fail++; $display("FAIL rst_ovr_rdata: got %h want 0", rdata); end
    rd(5'd10, 5'd11); #1;
    n_cmp++; if (rbusy !== 2'b00) begin n_fail++; $display("FAIL rst_ovr_rbusy: got %b want 00", rbusy); end
  endtask

  initial begin
    test_reset();
    test_alloc();
    test_write_bypass();
    test_release_realloc();
    test_flush();
    test_r0();
    test_reset_override();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_scoreboard.md
RF_SCOREBOARD -- requirements
Module: rf_scoreboard

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning the register data width in bits.
REQ-002 The block SHALL have parameter NREG, default 32, meaning the number of architectural registers; NREG is a power of two and at least 2.
REQ-003 The block SHALL have parameter NRP, default 2, meaning the number of read ports.
REQ-004 The block SHALL have parameter ZERO_R0, default 1, meaning register 0 reads as 0 and ignores writes and allocations.
REQ-005 The block SHALL use derived constant AW = clog2(NREG).
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 The block SHALL have port raddr, input, NRP*AW bits: read addresses, with port i at bits [i*AW +: AW].
REQ-009 The block SHALL have port rdata, output, NRP*XLEN bits: read data, one field per read port.
REQ-010 The block SHALL have port rbusy, output, NRP bits: busy flag of each addressed register.
REQ-011 The block SHALL have ports we (input, 1 bit), waddr (input, AW bits) and wdata (input, XLEN bits): the writeback port.
REQ-012 The block SHALL have ports alloc_valid (input, 1 bit), alloc_addr (input, AW bits) and alloc_ready (output, 1 bit): the destination-allocation handshake.
REQ-013 The block SHALL have port flush, input, 1 bit: clears every busy bit.
REQ-014 The block SHALL have port busy_cnt, output, AW+1 bits: the number of registers currently busy.

Function
REQ-015 Reads SHALL be combinational; rdata[i] = wdata when we=1 and waddr=raddr[i] (bypass), otherwise the stored value.
REQ-016 With ZERO_R0=1, a read of address 0 SHALL return 0 and rbusy 0, regardless of the bypass.
REQ-017 rbusy[i] SHALL equal busy[raddr[i]] with the writeback clear bypassed in the same cycle: same-cycle we to that address forces 0.
REQ-018 A write with we=1 SHALL store wdata at the next edge and clear busy[waddr]; with ZERO_R0=1 a write to address 0 is dropped.
REQ-019 A write to a non-busy register SHALL be accepted, updating data with busy unchanged.
REQ-020 alloc_ready SHALL be 1 iff flush=0 and either busy[alloc_addr]=0, or we=1 and waddr=alloc_addr (same-cycle release).
REQ-021 An allocation SHALL occur when alloc_valid and alloc_ready are both 1; it sets busy[alloc_addr] at the next edge.
REQ-022 An allocation to address 0 with ZERO_R0=1 SHALL always be ready and SHALL set nothing.
REQ-023 When a write and an allocation target the same register in the same cycle, the allocation SHALL win and busy ends at 1.
REQ-024 flush=1 SHALL clear all busy bits at the next edge; a write in the same cycle still updates data; allocation is refused (alloc_ready=0).
REQ-025 busy_cnt SHALL be registered and equal the popcount of the busy bits after each edge; it SHALL be updated incrementally (+1 alloc, -1 clear, net 0 when both hit different registers, 0 on flush) and never wrap.
REQ-026 alloc_valid held with alloc_ready=0 SHALL cause no state change.

Reset
REQ-027 With rst=1 at an edge, all registers SHALL become 0, all busy bits 0 and busy_cnt 0; rst overrides we, alloc and flush in the same cycle.
REQ-028 While rst=1, the outputs SHALL reflect the cleared state from the cycle after the first reset edge; combinational outputs still follow their inputs.

Structure
REQ-029 XLEN/NREG defaults and a clog2 helper SHALL live in a shared core package.
REQ-030 The scoreboard (busy bits, alloc_ready, busy_cnt) SHALL be a sub-module rf_busy_table; the data array and bypass SHALL stay in the top level.

Verification
REQ-031 Reset, then read ports 3 and 0 -> rdata 0/0, rbusy 0/0, busy_cnt 0.
REQ-032 Allocate r5, then next cycle read r5 -> rbusy 1, busy_cnt 1; allocate r5 again -> alloc_ready 0.
REQ-033 Write r5=0xDEADBEEF with a same-cycle read of r5 -> rdata 0xDEADBEEF and rbusy 0 that cycle; busy_cnt 0 after the edge.
REQ-034 Busy r7 with a same-cycle write r7 plus alloc r7 -> alloc_ready 1; busy stays 1 and busy_cnt is unchanged.
REQ-035 Allocate r1, r2, r3, then flush with alloc_valid r4 -> alloc_ready 0; busy_cnt 0 next cycle; no rbusy asserted.
REQ-036 Write r0=0x1234 and allocate r0 -> read r0 returns 0, rbusy 0, busy_cnt 0.
